// File: rtl/crtc_pkg.sv
// Shared constants for the CRTC/Z80 bus arbiter: FSM state codes, default
// timing parameters and counter widths.
package crtc_pkg;

  localparam int MIN_CPU_GAP_DEF = 16;
  localparam int ACK_TIMEOUT_DEF = 4095;

  localparam int TMO_W = 12;
  localparam int GAP_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_GRANT   = 3'd2;
  localparam state_t ST_RELEASE = 3'd3;
  localparam state_t ST_HOLDOFF = 3'd4;

  typedef logic [TMO_W-1:0] tmo_cnt_t;
  typedef logic [GAP_W-1:0] gap_cnt_t;

  // The wait counter parks at all-ones instead of wrapping back to zero.
  function automatic tmo_cnt_t tmo_sat_inc(input tmo_cnt_t v);
    return (&v) ? v : v + tmo_cnt_t'(1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous Z80 strobes; both flops reset to
// RESET_VAL so an idle-high strobe reads inactive straight out of reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/crtc_busarb.sv
// Arbitrates the shared video RAM between the Z80 and CRTC row-fetch DMA,
// using the Z80 BUSRQ/BUSAK handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | CPU owns the bus, waiting for a CRTC request
//   REQ     | BUSRQ asserted, waiting for BUSAK (cancel / timeout possible)
//   GRANT   | CRTC owns the bus, RAM address taken from crtc_adr
//   RELEASE | BUSRQ released, waiting for BUSAK to return high
//   HOLDOFF | guaranteed CPU window before the next CRTC request
module crtc_busarb
  import crtc_pkg::*;
#(
  parameter int MIN_CPU_GAP = MIN_CPU_GAP_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        crtc_busreq,
  output logic        crtc_busack,
  input  logic [16:0] crtc_adr,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  output logic [16:0] ram_adr,
  output logic        ram_we,
  output logic        dma_active,
  output logic        err_timeout
);

  state_t   state;
  state_t   state_next;
  tmo_cnt_t tmo_cnt;
  gap_cnt_t gap_cnt;
  logic     busak_s;
  logic     tmo_last;
  logic     gap_last;
  logic     timeout_hit;
  logic     in_grant;

  sync2 #(.RESET_VAL(1'b1)) u_sync_busak (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (cpu_busak_n),
    .q       (busak_s)
  );

  // Extended by one bit so the "+1" never wraps and a zero parameter
  // still terminates after a single cycle.
  assign tmo_last = ({1'b0, tmo_cnt} + 13'd1) >= 13'(ACK_TIMEOUT);
  assign gap_last = ({1'b0, gap_cnt} + 17'd1) >= 17'(MIN_CPU_GAP);

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (crtc_busreq) state_next = ST_REQ;
      end
      ST_REQ: begin
        // A cancel beats an acknowledge arriving in the same cycle.
        if (!crtc_busreq) begin
          state_next = ST_RELEASE;
        end else if (!busak_s) begin
          state_next = ST_GRANT;
        end else if (tmo_last) begin
          state_next  = ST_RELEASE;
          timeout_hit = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!crtc_busreq) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (busak_s) state_next = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (gap_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cpu_busrq_n <= 1'b1;
      crtc_busack <= 1'b0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_next;
      cpu_busrq_n <= !((state_next == ST_REQ) || (state_next == ST_GRANT));
      crtc_busack <= (state_next == ST_GRANT);
      if (timeout_hit) err_timeout <= 1'b1;

      if ((state != ST_REQ) && (state_next == ST_REQ)) begin
        tmo_cnt <= '0;
      end else if (state == ST_REQ) begin
        tmo_cnt <= tmo_sat_inc(tmo_cnt);
      end

      if ((state != ST_HOLDOFF) && (state_next == ST_HOLDOFF)) begin
        gap_cnt <= '0;
      end else if (state == ST_HOLDOFF) begin
        gap_cnt <= gap_cnt + gap_cnt_t'(1);
      end
    end
  end

  assign in_grant   = (state == ST_GRANT);
  assign dma_active = in_grant;

  // reset_n gates the write strobe so nothing lands in RAM while held in reset.
  assign ram_adr = in_grant ? crtc_adr : {1'b0, cpu_adr};
  assign ram_we  = reset_n & ~in_grant & ~cpu_mreq_n & ~cpu_wr_n;

endmodule
